// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_controller
//  Purpose  : Time-setting controller for a 24-hour digital clock. Walks
//             RUN -> SET_HOUR -> SET_MIN -> COMMIT on debounced button pulses,
//             freezes the timekeeper while editing, drives display blink
//             enables and issues a one-cycle parallel load on commit.
//  Ports    : clk, reset_n (async, active low)
//             sec_tick              1 Hz single-cycle pulse
//             btn_mode/inc/dec      single-cycle button pulses
//             cur_hour[4:0]         live hours   0..23
//             cur_min[5:0]          live minutes 0..59
//             hold                  timekeeper must ignore sec_tick
//             load                  one-cycle load strobe
//             load_hour/min/sec     values to load (seconds always 0)
//             mode[1:0]             0=RUN 1=SET_HOUR 2=SET_MIN 3=COMMIT
//             blink_hour/blink_min  digit blanking enables
//  Revision : 1.0  initial release
// ============================================================================
module clock_set_controller #(
  parameter int TIMEOUT_SECS = 10   // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  output logic       hold,
  output logic       load,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [1:0] mode,
  output logic       blink_hour,
  output logic       blink_min
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam logic [4:0] C_HOUR_MAX = 5'd23;
  localparam logic [5:0] C_MIN_MAX  = 6'd59;
  // Idle count value at which the next sec_tick is the aborting one.
  localparam logic [7:0] C_IDLE_LAST = 8'(TIMEOUT_SECS - 1);

  state_t     state_q, state_d;
  logic [4:0] edit_hour_q, edit_hour_d;
  logic [5:0] edit_min_q, edit_min_d;
  logic [7:0] idle_q, idle_d;
  logic       phase_q, phase_d;
  logic       hold_q, hold_d;
  logic       load_q, load_d;
  logic [4:0] load_hour_q, load_hour_d;
  logic [5:0] load_min_q, load_min_d;
  logic       blink_hour_q, blink_hour_d;
  logic       blink_min_q, blink_min_d;

  logic any_btn;
  logic step_up;
  logic step_dn;

  // inc and dec together cancel; the press still counts as activity.
  assign any_btn = btn_mode | btn_inc | btn_dec;
  assign step_up = btn_inc & ~btn_dec;
  assign step_dn = btn_dec & ~btn_inc;

  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    idle_d      = idle_q;
    phase_d     = phase_q;

    case (state_q)
      RUN: begin
        if (btn_mode) begin
          // Out-of-range live values are clamped so the edit fields stay legal.
          edit_hour_d = (cur_hour > C_HOUR_MAX) ? 5'd0 : cur_hour;
          edit_min_d  = (cur_min > C_MIN_MAX) ? 6'd0 : cur_min;
          idle_d      = 8'd0;
          phase_d     = 1'b1;
          state_d     = SET_HOUR;
        end
      end

      SET_HOUR, SET_MIN: begin
        if (sec_tick) begin
          phase_d = ~phase_q;
        end
        if (any_btn) begin
          // Any button is activity: it wins over a timeout-reaching tick.
          idle_d = 8'd0;
          if (btn_mode) begin
            // Mode wins over a simultaneous step.
            if (state_q == SET_HOUR) begin
              state_d = SET_MIN;
              phase_d = 1'b1;
            end else begin
              state_d = COMMIT;
            end
          end else if (state_q == SET_HOUR) begin
            if (step_up) begin
              edit_hour_d = (edit_hour_q >= C_HOUR_MAX) ? 5'd0 : edit_hour_q + 5'd1;
            end else if (step_dn) begin
              edit_hour_d = (edit_hour_q == 5'd0 || edit_hour_q > C_HOUR_MAX)
                            ? C_HOUR_MAX : edit_hour_q - 5'd1;
            end
          end else begin
            if (step_up) begin
              edit_min_d = (edit_min_q >= C_MIN_MAX) ? 6'd0 : edit_min_q + 6'd1;
            end else if (step_dn) begin
              edit_min_d = (edit_min_q == 6'd0 || edit_min_q > C_MIN_MAX)
                           ? C_MIN_MAX : edit_min_q - 6'd1;
            end
          end
        end else if (sec_tick) begin
          if (idle_q >= C_IDLE_LAST) begin
            // Abort: discard the edit, no load.
            state_d = RUN;
            idle_d  = 8'd0;
            phase_d = 1'b1;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
      end

      COMMIT: begin
        state_d = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    hold_d       = (state_d != RUN);
    load_d       = (state_d == COMMIT);
    load_hour_d  = load_d ? edit_hour_d : load_hour_q;
    load_min_d   = load_d ? edit_min_d : load_min_q;
    blink_hour_d = (state_d == SET_HOUR) && phase_d;
    blink_min_d  = (state_d == SET_MIN) && phase_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      edit_hour_q  <= 5'd0;
      edit_min_q   <= 6'd0;
      idle_q       <= 8'd0;
      phase_q      <= 1'b1;
      hold_q       <= 1'b0;
      load_q       <= 1'b0;
      load_hour_q  <= 5'd0;
      load_min_q   <= 6'd0;
      blink_hour_q <= 1'b0;
      blink_min_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      edit_hour_q  <= edit_hour_d;
      edit_min_q   <= edit_min_d;
      idle_q       <= idle_d;
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      load_q       <= load_d;
      load_hour_q  <= load_hour_d;
      load_min_q   <= load_min_d;
      blink_hour_q <= blink_hour_d;
      blink_min_q  <= blink_min_d;
    end
  end

  assign mode       = state_q;
  assign hold       = hold_q;
  assign load       = load_q;
  assign load_hour  = load_hour_q;
  assign load_min   = load_min_q;
  assign load_sec   = 6'd0;
  assign blink_hour = blink_hour_q;
  assign blink_min  = blink_min_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_set_controller
//  Purpose  : Directed self-checking bench for clock_set_controller
//             (instantiated with TIMEOUT_SECS = 3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic       hold;
  logic       load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [1:0] mode;
  logic       blink_hour;
  logic       blink_min;

  int n_cmp  = 0;
  int n_fail = 0;

  clock_set_controller #(.TIMEOUT_SECS(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sec_tick   (sec_tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .hold       (hold),
    .load       (load),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .mode       (mode),
    .blink_hour (blink_hour),
    .blink_min  (blink_min)
  );

  always #5 clk = ~clk;

  // Called at a negedge: drive inputs, let one posedge pass, return at the
  // following negedge with inputs cleared and outputs settled.
  task automatic step(input logic m, input logic i, input logic d, input logic t);
    btn_mode = m; btn_inc = i; btn_dec = d; sec_tick = t;
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; sec_tick = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cur_hour = 5'd13; cur_min = 6'd45;
    @(negedge clk);
    n_cmp++;
    if ({mode, hold, load, load_hour, load_min, load_sec, blink_hour, blink_min} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_state: got mode=%0d hold=%b load=%b lh=%0d lm=%0d ls=%0d bh=%b bm=%b, want all 0",
               mode, hold, load, load_hour, load_min, load_sec, blink_hour, blink_min);
    end
    reset_n = 1'b1;
    @(negedge clk);
    step(1, 0, 0, 0);
    n_cmp++;
    if ({mode, hold, blink_hour, blink_min, load} !== {2'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL enter_edit: got mode=%0d hold=%b bh=%b bm=%b load=%b, want 1 1 1 0 0",
               mode, hold, blink_hour, blink_min, load);
    end
    step(1, 0, 0, 0);   // SET_MIN
    step(1, 0, 0, 0);   // COMMIT
    n_cmp++;
    if ({mode, load, load_hour, load_min} !== {2'd3, 1'b1, 5'd13, 6'd45}) begin
      n_fail++;
      $display("FAIL capture_commit: got mode=%0d load=%b lh=%0d lm=%0d, want 3 1 13 45",
               mode, load, load_hour, load_min);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_full_edit;
    logic prev_load;
    int   n_loads;
    step(1, 0, 0, 0);
    for (int k = 0; k < 11; k++) step(0, 1, 0, 0);   // 13 -> 23 -> 0
    step(1, 0, 0, 0);
    n_cmp++;
    if ({mode, blink_min, blink_hour} !== {2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL to_set_min: got mode=%0d bm=%b bh=%b, want 2 1 0", mode, blink_min, blink_hour);
    end
    for (int k = 0; k < 46; k++) step(0, 0, 1, 0);   // 45 -> 0 -> 59
    step(1, 0, 0, 0);
    n_cmp++;
    if ({load, load_hour, load_min, load_sec, mode, hold, blink_hour, blink_min} !==
        {1'b1, 5'd0, 6'd59, 6'd0, 2'd3, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL full_commit: got load=%b lh=%0d lm=%0d ls=%0d mode=%0d hold=%b bh=%b bm=%b, want 1 0 59 0 3 1 0 0",
               load, load_hour, load_min, load_sec, mode, hold, blink_hour, blink_min);
    end
    prev_load = load;
    n_loads = 1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      if (load) n_loads++;
      n_cmp++;
      if (prev_load && load) begin
        n_fail++;
        $display("FAIL load_back_to_back: got load=1 twice in a row, want single pulse");
      end
      prev_load = load;
    end
    n_cmp++;
    if ({mode, hold, n_loads[1:0], load_hour, load_min} !== {2'd0, 1'b0, 2'd1, 5'd0, 6'd59}) begin
      n_fail++;
      $display("FAIL after_commit: got mode=%0d hold=%b loads=%0d lh=%0d lm=%0d, want 0 0 1 0 59",
               mode, hold, n_loads, load_hour, load_min);
    end
  endtask

  task automatic test_timeout;
    logic saw_load;
    saw_load = 1'b0;
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if ({mode, hold} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_early: got mode=%0d hold=%b after 2 ticks, want 1 1", mode, hold);
    end
    step(0, 0, 0, 1);
    saw_load = load;
    step(0, 0, 0, 0);
    saw_load = saw_load | load;
    n_cmp++;
    if ({mode, hold, saw_load, blink_hour} !== {2'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_abort: got mode=%0d hold=%b load_seen=%b bh=%b, want 0 0 0 0",
               mode, hold, saw_load, blink_hour);
    end
    // Button on the cycle of the third tick keeps the edit alive.
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    n_cmp++;
    if ({mode, hold} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_button_wins: got mode=%0d hold=%b, want 1 1", mode, hold);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    n_cmp++;
    if (mode !== 2'd1) begin
      n_fail++;
      $display("FAIL timeout_counter_cleared: got mode=%0d after 2 more ticks, want 1", mode);
    end
    step(0, 0, 0, 1);
    n_cmp++;
    if ({mode, hold, load} !== {2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_second_abort: got mode=%0d hold=%b load=%b, want 0 0 0", mode, hold, load);
    end
  endtask

  task automatic test_simultaneous;
    cur_hour = 5'd13; cur_min = 6'd45;
    step(1, 0, 0, 1);   // tick on entry has no effect
    n_cmp++;
    if ({mode, blink_hour} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL entry_tick: got mode=%0d bh=%b, want 1 1", mode, blink_hour);
    end
    step(0, 1, 1, 0);   // inc+dec cancel
    step(1, 1, 0, 0);   // mode wins over inc
    n_cmp++;
    if (mode !== 2'd2) begin
      n_fail++;
      $display("FAIL mode_with_inc: got mode=%0d, want 2", mode);
    end
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);   // mode wins over dec
    n_cmp++;
    if ({mode, load, load_hour, load_min} !== {2'd3, 1'b1, 5'd13, 6'd45}) begin
      n_fail++;
      $display("FAIL simultaneous_fields: got mode=%0d load=%b lh=%0d lm=%0d, want 3 1 13 45",
               mode, load, load_hour, load_min);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_wrap;
    cur_hour = 5'd0; cur_min = 6'd59;
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);   // 0 -> 23
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);   // 59 -> 0
    step(0, 1, 0, 0);   // 0 -> 1
    step(0, 0, 1, 0);   // 1 -> 0
    step(1, 0, 0, 0);
    n_cmp++;
    if ({load, load_hour, load_min} !== {1'b1, 5'd23, 6'd0}) begin
      n_fail++;
      $display("FAIL wrap_bounds: got load=%b lh=%0d lm=%0d, want 1 23 0", load, load_hour, load_min);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_blink;
    logic [4:0] seq_min;
    logic [4:0] seq_hour;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    seq_min[4] = blink_min;  seq_hour[4] = blink_hour;
    step(0, 0, 0, 1);
    seq_min[3] = blink_min;  seq_hour[3] = blink_hour;
    step(0, 0, 0, 1);
    seq_min[2] = blink_min;  seq_hour[2] = blink_hour;
    step(0, 1, 0, 0);        // keep idle counter below the timeout
    step(0, 0, 0, 1);
    seq_min[1] = blink_min;  seq_hour[1] = blink_hour;
    step(0, 0, 0, 1);
    seq_min[0] = blink_min;  seq_hour[0] = blink_hour;
    n_cmp++;
    if ({seq_min, seq_hour, mode} !== {5'b10101, 5'b00000, 2'd2}) begin
      n_fail++;
      $display("FAIL blink_seq: got bm=%b bh=%b mode=%0d, want 10101 00000 2", seq_min, seq_hour, mode);
    end
    step(1, 0, 0, 0);
    n_cmp++;
    if ({blink_hour, blink_min, load} !== {1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL blink_commit: got bh=%b bm=%b load=%b, want 0 0 1", blink_hour, blink_min, load);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_edit;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mode, hold, load, blink_min} !== {2'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got mode=%0d hold=%b load=%b bm=%b, want 0 0 0 0",
               mode, hold, load, blink_min);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cur_hour = 5'd7; cur_min = 6'd30;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_cmp++;
    if ({load, load_hour, load_min} !== {1'b1, 5'd7, 6'd30}) begin
      n_fail++;
      $display("FAIL recapture: got load=%b lh=%0d lm=%0d, want 1 7 30", load, load_hour, load_min);
    end
    step(0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_edit();
    test_timeout();
    test_simultaneous();
    test_wrap();
    test_blink();
    test_reset_mid_edit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
